// File: rtl/idma_tpram_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// idma_tpram_fifo_ctrl_if
// Purpose : bundles the stream handshakes, occupancy and two-port RAM bus of
//           the TPRAM FIFO controller into one interface.
// Signals :
//   flush                 synchronous clear request into the controller
//   s_valid/s_ready/s_data write-side stream (into the FIFO)
//   m_valid/m_ready/m_data read-side stream (out of the FIFO)
//   level                 total occupancy, RAM plus in-flight plus buffered
//   mem_wceb/waddr/wdata  RAM write port, enable active-low
//   mem_rceb/raddr/rdata  RAM read port, enable active-low, data registered
// Modports:
//   slave  - the controller
//   master - whatever drives the streams and hosts the RAM
// ---------------------------------------------------------------------------
interface idma_tpram_fifo_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW:0]   level;
    logic          mem_wceb;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rceb;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  flush, s_valid, s_data, m_ready, mem_rdata,
        output s_ready, m_valid, m_data, level,
               mem_wceb, mem_waddr, mem_wdata, mem_rceb, mem_raddr
    );

    modport master (
        output flush, s_valid, s_data, m_ready, mem_rdata,
        input  s_ready, m_valid, m_data, level,
               mem_wceb, mem_waddr, mem_wdata, mem_rceb, mem_raddr
    );
endinterface

// File: rtl/idma_tpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// idma_tpram_fifo_ctrl
// Purpose : FIFO controller around an external two-port RAM (one write port,
//           one registered read port). A two-entry output buffer absorbs the
//           one-cycle RAM read latency so the read side runs without bubbles.
//           Capacity is the RAM depth plus two.
// Ports   :
//   clk  - single clock for all state and both RAM ports
//   rst  - asynchronous active-high reset
//   bus  - idma_tpram_fifo_ctrl_if.slave (streams, flush, level, RAM bus)
// ---------------------------------------------------------------------------
module idma_tpram_fifo_ctrl #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    idma_tpram_fifo_ctrl_if.slave bus
);
    localparam logic [AW:0] FULL = (AW+1)'(2**AW);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic [1:0]    obuf_cnt_q, obuf_cnt_d;
    logic [DW-1:0] obuf_q [2];
    logic [DW-1:0] obuf_d [2];

    logic          s_ready;
    logic          m_valid;
    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    occ_next;

    // Write side: refuse while in reset, flushing, or with the RAM full.
    assign s_ready = !rst && !bus.flush && (ram_cnt_q != FULL);
    assign push    = bus.s_valid && s_ready;

    // Read side: a word is available from the buffer or, bypassing it,
    // straight off the RAM read port when a read landed this cycle.
    assign m_valid = (obuf_cnt_q != 2'd0) || rd_pend_q;
    assign pop     = m_valid && bus.m_ready;

    // Only issue a RAM read if its data is guaranteed a buffer slot next
    // cycle, counting words already buffered or in flight minus this pop.
    assign occ_next = {1'b0, obuf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue    = !bus.flush && (ram_cnt_q != '0) && (occ_next < 3'd2);

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = (obuf_cnt_q != 2'd0) ? obuf_q[0] : bus.mem_rdata;
    assign bus.level     = ram_cnt_q + (AW+1)'(rd_pend_q) + (AW+1)'(obuf_cnt_q);
    assign bus.mem_wceb  = !push;
    assign bus.mem_waddr = wptr_q;
    assign bus.mem_wdata = bus.s_data;
    assign bus.mem_rceb  = !issue;
    assign bus.mem_raddr = rptr_q;

    // Next-state logic. The output buffer is a two-deep shift queue with the
    // head in slot 0: a pop from the buffer shifts it down, then any RAM word
    // arriving this cycle is appended unless the bypass already consumed it.
    // A flush wipes every counter; buffered data becomes unreachable.
    always_comb begin
        wptr_d     = wptr_q + AW'(push);
        rptr_d     = rptr_q + AW'(issue);
        ram_cnt_d  = ram_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
        rd_pend_d  = issue;
        obuf_d     = obuf_q;
        obuf_cnt_d = obuf_cnt_q;

        if (pop && (obuf_cnt_q != 2'd0)) begin
            obuf_d[0]  = obuf_q[1];
            obuf_cnt_d = obuf_cnt_d - 2'd1;
        end
        if (rd_pend_q && !(pop && (obuf_cnt_q == 2'd0))) begin
            obuf_d[obuf_cnt_d[0]] = bus.mem_rdata;
            obuf_cnt_d            = obuf_cnt_d + 2'd1;
        end

        if (bus.flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            ram_cnt_d  = '0;
            rd_pend_d  = 1'b0;
            obuf_cnt_d = 2'd0;
        end
    end

    // Control state; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            obuf_cnt_q <= 2'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            rd_pend_q  <= rd_pend_d;
            obuf_cnt_q <= obuf_cnt_d;
        end
    end

    // Buffer payload carries no reset; obuf_cnt_q alone says what is valid.
    always_ff @(posedge clk) begin
        obuf_q <= obuf_d;
    end
endmodule

// File: tb/tb_idma_tpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_idma_tpram_fifo_ctrl
// Directed bench for the TPRAM FIFO controller. A behavioural two-port RAM
// with registered read sits on the memory bus. Accepted words are queued as
// expected output; a monitor pops that queue whenever a word leaves the FIFO.
// ---------------------------------------------------------------------------
module tb_idma_tpram_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst;

    idma_tpram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    idma_tpram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] ramArray [2**AW];
    logic [DW-1:0] ramRdata;

    int            compared   = 0;
    int            mismatched = 0;
    logic [31:0]   sbQueue [$];
    int            acceptCnt  = 0;
    int            wWraps     = 0;
    int            rWraps     = 0;
    logic [AW-1:0] lastW;
    logic [AW-1:0] lastR;

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-port RAM model: read data appears the cycle after rceb is sampled low
    assign bus.mem_rdata = ramRdata;
    always @(posedge clk) begin
        if (!bus.mem_wceb) ramArray[bus.mem_waddr] <= bus.mem_wdata;
        if (!bus.mem_rceb) ramRdata <= ramArray[bus.mem_raddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] d,
                                 input logic mr, input logic fl);
        bus.s_valid = sv;
        bus.s_data  = d;
        bus.m_ready = mr;
        bus.flush   = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stop writing, read everything out, and confirm nothing is left over
    task automatic drain(input string tag);
        bit done = 1'b0;
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.level == '0 && sbQueue.size() == 0) done = 1'b1;
            else tick();
        end
        checkOutput({tag, "_level"}, 32'(bus.level), 32'd0);
        checkOutput({tag, "_mvalid"}, 32'(bus.m_valid), 32'd0);
        checkOutput({tag, "_sb_left"}, 32'(sbQueue.size()), 32'd0);
    endtask

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            sbQueue.delete();
            lastW = '0;
            lastR = '0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (sbQueue.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_output: got 0x%08h, expected no output", bus.m_data);
                end else begin
                    checkOutput("m_data_order", bus.m_data, sbQueue.pop_front());
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                sbQueue.push_back(bus.s_data);
                acceptCnt++;
            end
            if (!bus.mem_wceb) begin
                if (lastW == '1 && bus.mem_waddr == '0) wWraps++;
                lastW = bus.mem_waddr;
            end
            if (!bus.mem_rceb) begin
                if (lastR == '1 && bus.mem_raddr == '0) rWraps++;
                lastR = bus.mem_raddr;
            end
            if (bus.flush) sbQueue.delete();
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int wBase;
        int rBase;
        int bubbles;
        int maxLvl;
        int k;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("rst_level", 32'(bus.level), 32'd0);
        checkOutput("rst_wceb", 32'(bus.mem_wceb), 32'd1);
        checkOutput("rst_rceb", 32'(bus.mem_rceb), 32'd1);
        tick();
        rst = 1'b0;

        // Single word latency
        $display("[TB] single word latency");
        applyStimulus(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("lat_T_level", 32'(bus.level), 32'd0);
        checkOutput("lat_T_s_ready", 32'(bus.s_ready), 32'd1);
        checkOutput("lat_T_wceb", 32'(bus.mem_wceb), 32'd0);
        checkOutput("lat_T_waddr", 32'(bus.mem_waddr), 32'd0);
        checkOutput("lat_T_wdata", bus.mem_wdata, 32'hA5A5_0001);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("lat_T1_level", 32'(bus.level), 32'd1);
        checkOutput("lat_T1_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("lat_T1_rceb", 32'(bus.mem_rceb), 32'd0);
        checkOutput("lat_T1_raddr", 32'(bus.mem_raddr), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("lat_T2_m_valid", 32'(bus.m_valid), 32'd1);
        checkOutput("lat_T2_m_data", bus.m_data, 32'hA5A5_0001);
        tick();
        @(negedge clk);
        checkOutput("lat_T3_level", 32'(bus.level), 32'd0);
        checkOutput("lat_T3_m_valid", 32'(bus.m_valid), 32'd0);

        // Fill to capacity with the reader stalled
        $display("[TB] capacity fill");
        tick();
        base = acceptCnt;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("cap_accepted", 32'(acceptCnt - base), 32'd34);
        checkOutput("cap_s_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("cap_level", 32'(bus.level), 32'd34);
        drain("cap_drain");

        // Streaming throughput
        $display("[TB] streaming throughput");
        tick();
        base    = acceptCnt;
        bubbles = 0;
        maxLvl  = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0);
            @(negedge clk);
            if (i >= 2 && !bus.m_valid) bubbles++;
            if (int'(bus.level) > maxLvl) maxLvl = int'(bus.level);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("thru_accepted", 32'(acceptCnt - base), 32'd100);
        checkOutput("thru_bubbles", 32'(bubbles), 32'd0);
        checkOutput("thru_level_le2", 32'(maxLvl <= 2), 32'd1);
        drain("thru_drain");

        // Random handshakes across pointer wrap, starting from reset
        $display("[TB] random handshakes with wrap");
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        wBase = wWraps;
        rBase = rWraps;
        k     = 0;
        for (int cyc = 0; cyc < 2000 && k < 70; cyc++) begin
            logic sv;
            logic mr;
            sv = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            applyStimulus(sv, 32'h4000 + 32'(k), mr, 1'b0);
            @(negedge clk);
            if (sv && bus.s_ready) k++;
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rand_words_sent", 32'(k), 32'd70);
        drain("rand_drain");
        checkOutput("rand_waddr_wraps", 32'(wWraps - wBase), 32'd2);
        checkOutput("rand_raddr_wraps", 32'(rWraps - rBase), 32'd2);

        // Flush at level 10 with a read in flight
        $display("[TB] flush");
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("flush_pre_level", 32'(bus.level), 32'd10);
        tick();
        applyStimulus(1'b1, 32'h50A, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush_cycle_level", 32'(bus.level), 32'd10);
        checkOutput("flush_cycle_wceb", 32'(bus.mem_wceb), 32'd1);
        checkOutput("flush_cycle_rceb", 32'(bus.mem_rceb), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush_post_level", 32'(bus.level), 32'd0);
        checkOutput("flush_post_m_valid", 32'(bus.m_valid), 32'd0);
        tick();
        applyStimulus(1'b1, 32'h1234, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("flush_next_m_valid", 32'(bus.m_valid), 32'd1);
        checkOutput("flush_next_m_data", bus.m_data, 32'h1234);
        drain("flush_drain");

        // Asynchronous reset mid-stream at level 20
        $display("[TB] async reset mid-stream");
        tick();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("arst_pre_level", 32'(bus.level), 32'd20);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_level", 32'(bus.level), 32'd0);
        checkOutput("arst_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("arst_s_ready", 32'(bus.s_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h700 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        drain("arst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/idma_tpram_fifo_ctrl.md
IDMA_TPRAM_FIFO_CTRL -- requirements
Module: idma_tpram_fifo_ctrl

Interface
REQ-001 Parameter DW, 32: data width, equal to the two-port RAM word width.
REQ-002 Parameter AW, 5: RAM address width; RAM depth is 2^AW = 32.
REQ-003 clk  in  1: single clock for all state and both RAM ports.
REQ-004 rst  in  1: asynchronous, active-high reset.
REQ-005 flush  in  1: synchronous clear of all contents.
REQ-006 s_valid  in  1: write-side data valid.
REQ-007 s_ready  out  1: write-side ready.
REQ-008 s_data  in  DW: write-side data.
REQ-009 m_valid  out  1: read-side data valid.
REQ-010 m_ready  in  1: read-side ready.
REQ-011 m_data  out  DW: read-side data.
REQ-012 level  out  6: total occupancy, 0..34.
REQ-013 mem_wceb  out  1: RAM write enable, active-low.
REQ-014 mem_waddr  out  AW: RAM write address.
REQ-015 mem_wdata  out  DW: RAM write data, equal to s_data.
REQ-016 mem_rceb  out  1: RAM read enable, active-low.
REQ-017 mem_raddr  out  AW: RAM read address.
REQ-018 mem_rdata  in  DW: RAM read data, registered, valid the cycle after the RAM samples mem_rceb low.

Function
REQ-019 State: wptr and rptr (AW bits each), ram_cnt (0..32), rd_pend (1 bit, a read issued last cycle), and a 2-entry output buffer obuf with obuf_cnt (0..2).
REQ-020 s_ready = !rst && !flush && ram_cnt != 32; s_ready does not depend on m_ready.
REQ-021 push = s_valid && s_ready; on push, mem_wceb = 0 and mem_waddr = wptr, then wptr increments with wrap 31->0; otherwise mem_wceb = 1.
REQ-022 m_valid = (obuf_cnt != 0) || rd_pend; pop = m_valid && m_ready.
REQ-023 m_data = obuf head when obuf_cnt != 0, else mem_rdata (bypass); data order is strictly first-in first-out.
REQ-024 issue = !flush && ram_cnt != 0 && (obuf_cnt + rd_pend - pop) < 2; on issue, mem_rceb = 0 and mem_raddr = rptr, then rptr increments with wrap; otherwise mem_rceb = 1.
REQ-025 rd_pend <= issue each cycle.
REQ-026 When rd_pend is set, mem_rdata enters obuf unless it is consumed by the bypass pop in the same cycle.
REQ-027 ram_cnt next = ram_cnt + push - issue; simultaneous push and issue leaves it unchanged.
REQ-028 A read and a write never target the same address in one cycle: reads access only occupied entries and writes only free ones.
REQ-029 level = ram_cnt + rd_pend + obuf_cnt.
REQ-030 Capacity is 34 entries: 32 in RAM plus 2 in flight or buffered; with m_ready held at 0, s_ready falls once ram_cnt reaches 32.
REQ-031 Latency: a word pushed in cycle T with the controller empty gives m_valid = 1 in cycle T+2.
REQ-032 Throughput: with s_valid = m_ready = 1 continuously, the controller sustains one push and one pop per cycle with no bubbles.
REQ-033 On flush = 1: pointers, ram_cnt, rd_pend and obuf_cnt clear at the next edge; mem_wceb = mem_rceb = 1 in the flush cycle; no push or issue occurs; in-flight mem_rdata is discarded.

Reset
REQ-034 While rst is high: wptr = rptr = 0, ram_cnt = 0, rd_pend = 0, obuf_cnt = 0.
REQ-035 While rst is high: s_ready = 0, m_valid = 0, level = 0, mem_wceb = mem_rceb = 1; obuf data is don't-care.
REQ-036 Reset asserted mid-operation discards all contents immediately; s_ready = 1 is allowed from the first cycle after rst falls.

Verification
REQ-037 Empty, m_ready = 1, one push of 0xA5A50001 in cycle T -> level = 1 in T+1, m_valid = 1 with m_data = 0xA5A50001 in T+2, level = 0 in T+3.
REQ-038 m_ready = 0, s_valid = 1 for 40 cycles with data 0..39 -> exactly 34 accepted, s_ready = 0, level = 34; then m_ready = 1 -> 0..33 out in order and level returns to 0.
REQ-039 s_valid = m_ready = 1 for 100 words -> after the 2-cycle fill, m_valid stays 1 every cycle, data in order, level stays at most 2.
REQ-040 70 words with random s_valid and m_ready -> output matches the scoreboard, and mem_waddr and mem_raddr each wrap 31->0 twice.
REQ-041 flush at level 10 with rd_pend = 1 -> next cycle level = 0 and m_valid = 0; a following push of 0x1234 is the next word output.
REQ-042 rst pulsed mid-stream at level 20 -> level = 0 and m_valid = 0 immediately without a clock edge; after release, a fresh stream passes intact.
